// File: rtl/sram_arbiter_if.sv
// SRAM-like request/response port shared by the inst, data and memory sides
// of sram_arbiter. master drives the request, slave answers it.
interface sram_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-to-one arbiter sharing one SRAM-like memory port between instruction
// fetch and data access; data has priority, inst is protected from starvation.
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          resetn,
  sram_arbiter_if.slave  inst,
  sram_arbiter_if.slave  data,
  sram_arbiter_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_owner;
  logic       w_owner_nxt;
  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       w_any_req;
  logic       w_data_wins;
  logic       w_arb;
  logic       w_in_req;
  logic       w_in_resp;

  // Arbitration: data wins ties until inst has been passed over LP_LIMIT times.
  always_comb begin
    w_any_req   = inst.req | data.req;
    w_data_wins = data.req & ~(inst.req & (r_starve_cnt == LP_LIMIT));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve_cnt;
    w_arb        = 1'b0;
    case (r_state)
      S_IDLE: w_arb = 1'b1;
      S_REQ: begin
        if (mem.addr_ok) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (mem.data_ok) begin
          w_arb       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A grant on completion goes straight to REQ, so back-to-back has no bubble.
    if (w_arb) begin
      if (w_any_req) begin
        w_state_nxt = S_REQ;
        w_owner_nxt = w_data_wins;
      end
      if (inst.req & w_data_wins) begin
        w_starve_nxt = (r_starve_cnt == LP_LIMIT) ? r_starve_cnt : r_starve_cnt + 4'd1;
      end else begin
        w_starve_nxt = '0;
      end
    end
  end

  always_comb begin
    w_in_req  = (r_state == S_REQ);
    w_in_resp = (r_state == S_RESP);

    mem.req   = w_in_req;
    mem.wr    = r_owner ? data.wr    : inst.wr;
    mem.size  = r_owner ? data.size  : inst.size;
    mem.wstrb = r_owner ? data.wstrb : inst.wstrb;
    mem.addr  = r_owner ? data.addr  : inst.addr;
    mem.wdata = r_owner ? data.wdata : inst.wdata;

    inst.addr_ok = w_in_req  & ~r_owner & mem.addr_ok;
    data.addr_ok = w_in_req  &  r_owner & mem.addr_ok;
    inst.data_ok = w_in_resp & ~r_owner & mem.data_ok;
    data.data_ok = w_in_resp &  r_owner & mem.data_ok;

    // Read data is shared; only the owner's data_ok qualifies it.
    inst.rdata = mem.rdata;
    data.rdata = mem.rdata;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: requester queues and a latency-programmable
// memory responder, with a scoreboard of expected grants and read data.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sram_arbiter_if inst_bus ();
  sram_arbiter_if data_bus ();
  sram_arbiter_if mem_bus ();

  sram_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .inst   (inst_bus),
    .data   (data_bus),
    .mem    (mem_bus)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        inst_stim[$];
  txn_t        data_stim[$];
  logic [31:0] inst_exp[$];
  logic [31:0] data_exp[$];
  logic        grant_q[$];
  logic [3:0]  starve_q[$];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int          lat_a, lat_d, cnt_a, cnt_d;
  logic        inflight, resp_owner, spur_aok, spur_dok, exp_req, held;
  logic [31:0] cur_rdata, held_addr;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a == 32'h1C00_0000) ? 32'h0280_0C0C : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic txn_t mk(input logic wr, input logic [3:0] wstrb,
                              input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.wr = wr; t.size = 2'd2; t.wstrb = wstrb; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic who, input txn_t t);
    if (who) begin
      data_stim.push_back(t);
      data_exp.push_back(rdata_of(t.addr));
    end else begin
      inst_stim.push_back(t);
      inst_exp.push_back(rdata_of(t.addr));
    end
  endtask

  task automatic drive_reqs();
    if (inst_stim.size() != 0) begin
      inst_bus.req = 1'b1;
      {inst_bus.wr, inst_bus.size, inst_bus.wstrb, inst_bus.addr, inst_bus.wdata} = inst_stim[0];
    end else begin
      inst_bus.req = 1'b0;
    end
    if (data_stim.size() != 0) begin
      data_bus.req = 1'b1;
      {data_bus.wr, data_bus.size, data_bus.wstrb, data_bus.addr, data_bus.wdata} = data_stim[0];
    end else begin
      data_bus.req = 1'b0;
    end
    exp_req = held ? 1'b1 : (inflight ? 1'b0 : (inst_bus.req | data_bus.req));
  endtask

  task automatic reset_model();
    inst_stim.delete(); data_stim.delete();
    inst_exp.delete();  data_exp.delete();
    grant_q.delete();   starve_q.delete();
    inflight = 1'b0; held = 1'b0; cnt_a = 0; cnt_d = 0;
    spur_aok = 1'b0; spur_dok = 1'b0; exp_req = 1'b0;
  endtask

  task automatic cycle();
    logic [1:0]  exp_aok, exp_dok;
    logic        acc, done, gid;
    logic [31:0] er;
    txn_t        t;
    @(posedge clk);
    #1;
    mem_bus.addr_ok = (mem_bus.req && cnt_a >= lat_a) || spur_aok;
    mem_bus.data_ok = (inflight && cnt_d >= lat_d) || spur_dok;
    mem_bus.rdata   = inflight ? cur_rdata : 32'hDEAD_BEEF;
    #1;
    acc  = mem_bus.addr_ok && !spur_aok;
    done = inflight && mem_bus.data_ok && !spur_dok;

    chk("mem_req", 72'(mem_bus.req), 72'(exp_req));
    if (held) chk("addr_hold", 72'(mem_bus.addr), 72'(held_addr));

    exp_aok = 2'b00;
    if (acc && grant_q.size() != 0) exp_aok = grant_q[0] ? 2'b01 : 2'b10;
    chk("addr_ok", 72'({inst_bus.addr_ok, data_bus.addr_ok}), 72'(exp_aok));

    exp_dok = done ? (resp_owner ? 2'b01 : 2'b10) : 2'b00;
    chk("data_ok", 72'({inst_bus.data_ok, data_bus.data_ok}), 72'(exp_dok));
    if (done) begin
      if (resp_owner && data_exp.size() != 0) begin
        er = data_exp.pop_front();
        chk("data_rdata", 72'(data_bus.rdata), 72'(er));
      end else if (!resp_owner && inst_exp.size() != 0) begin
        er = inst_exp.pop_front();
        chk("inst_rdata", 72'(inst_bus.rdata), 72'(er));
      end
      inflight = 1'b0;
    end else if (inflight) begin
      cnt_d++;
    end

    if (acc && grant_q.size() != 0) begin
      gid = grant_q.pop_front();
      t   = '0;
      if (gid) begin
        if (data_stim.size() != 0) t = data_stim.pop_front();
      end else if (inst_stim.size() != 0) begin
        t = inst_stim.pop_front();
      end
      chk("mem_fields", 72'({mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata}), 72'(t));
      if (starve_q.size() != 0) chk("starve_cnt", 72'(dut.r_starve_cnt), 72'(starve_q.pop_front()));
      inflight   = 1'b1;
      resp_owner = gid;
      cur_rdata  = rdata_of(t.addr);
      cnt_d      = 0;
    end

    if (mem_bus.req && !acc) begin
      held      = 1'b1;
      held_addr = mem_bus.addr;
      cnt_a++;
    end else begin
      held  = 1'b0;
      cnt_a = 0;
    end
    drive_reqs();
  endtask

  task automatic run(input int max);
    int   n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < max) begin
      cycle();
      n++;
      pending = (inst_stim.size() != 0) || (data_stim.size() != 0) || inflight || (grant_q.size() != 0);
    end
    chk("phase_timeout", 72'(pending), 72'(0));
    cycle();
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.size = 2'd0; inst_bus.wstrb = 4'h0;
    inst_bus.addr = 32'h1234_5678; inst_bus.wdata = 32'h0;
    data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.size = 2'd0; data_bus.wstrb = 4'h0;
    data_bus.addr = 32'h8765_4321; data_bus.wdata = 32'h0;
    mem_bus.addr_ok = 1'b1; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0;
    lat_a = 0; lat_d = 0;
    reset_model();

    // Reset state, with memory handshakes held high to show they are gated.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_req", 72'(mem_bus.req), 72'(0));
    chk("rst_oks", 72'({inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}), 72'(0));
    chk("rst_fields_inst", 72'(mem_bus.addr), 72'(32'h1234_5678));
    chk("rst_state", 72'(dut.r_state), 72'(0));
    chk("rst_starve", 72'(dut.r_starve_cnt), 72'(0));
    @(negedge clk);
    resetn = 1'b1;
    mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0;
    drive_reqs();

    // Single inst read.
    issue(1'b0, mk(1'b0, 4'h0, 32'h1C00_0000, 32'h0));
    grant_q.push_back(1'b0);
    drive_reqs();
    run(20);

    // Simultaneous inst read and data write: data first, inst back-to-back.
    issue(1'b0, mk(1'b0, 4'h0, 32'h1C00_0010, 32'h0));
    issue(1'b1, mk(1'b1, 4'hF, 32'h0000_2000, 32'h0000_A0F0));
    grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    drive_reqs();
    run(30);

    // Starvation guard: inst held while six data requests stream.
    issue(1'b0, mk(1'b0, 4'h0, 32'h1C00_0020, 32'h0));
    for (int i = 0; i < 6; i++) issue(1'b1, mk(1'b0, 4'h0, 32'h0000_3000 + 32'(i * 4), 32'h0));
    grant_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    starve_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0};
    drive_reqs();
    run(60);
    chk("starve_after", 72'(dut.r_starve_cnt), 72'(0));

    // Downstream stalls on both handshakes.
    lat_a = 5; lat_d = 7;
    issue(1'b1, mk(1'b1, 4'h3, 32'h0000_4000, 32'hCAFE_0001));
    issue(1'b0, mk(1'b0, 4'h0, 32'h1C00_0030, 32'h0));
    grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    drive_reqs();
    run(60);
    lat_a = 0; lat_d = 0;

    // Spurious handshakes while idle.
    spur_dok = 1'b1; cycle(); spur_dok = 1'b0;
    spur_aok = 1'b1; cycle(); spur_aok = 1'b0;
    cycle();
    chk("spur_state", 72'(dut.r_state), 72'(0));

    // Asynchronous reset in RESP, then a stale data_ok, then normal traffic.
    lat_d = 7;
    issue(1'b0, mk(1'b0, 4'h0, 32'h1C00_0040, 32'h0));
    grant_q.push_back(1'b0);
    drive_reqs();
    cycle();
    cycle();
    #1;
    resetn = 1'b0;
    mem_bus.addr_ok = 1'b1;
    mem_bus.data_ok = 1'b1;
    #1;
    chk("arst_outputs", 72'({mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok, inst_bus.data_ok, data_bus.data_ok}), 72'(0));
    chk("arst_state", 72'(dut.r_state), 72'(0));
    reset_model();
    lat_d = 0;
    @(negedge clk);
    resetn = 1'b1;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
    drive_reqs();
    spur_dok = 1'b1; cycle(); spur_dok = 1'b0;
    cycle();
    issue(1'b0, mk(1'b0, 4'h0, 32'h1C00_0000, 32'h0));
    grant_q.push_back(1'b0);
    drive_reqs();
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
